// File: rtl/mux_pipe_n_to_1.sv
// Registered N-to-1 selector with valid/ready on every channel and on the output.
// Grant comes from an explicit select or a round-robin pointer.
module mux_pipe_n_to_1 #(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    // Handshake: a channel k transfers on a rising edge where in_valid[k] & in_ready[k];
    // the output entry is consumed on an edge where out_valid & out_ready, and while
    // out_valid & ~out_ready the output register holds out_data/out_sel/out_valid.

    logic [SEL_W-1:0] rr_ptr;
    logic             load_en;
    logic             sel_ok;
    logic             grant_any;
    logic [N-1:0]     grant_oh;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] rr_next;
    logic [SEL_W-1:0] hi_pick;
    logic [SEL_W-1:0] lo_pick;
    logic             hi_found;
    logic             lo_found;

    assign load_en = ~out_valid | out_ready;

    // Round-robin: the first valid channel at or above rr_ptr wins; otherwise wrap
    // around to the lowest valid channel below it.
    always_comb begin
        hi_pick  = '0;
        lo_pick  = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[k]) begin
                lo_pick  = SEL_W'(k);
                lo_found = 1'b1;
                if (SEL_W'(k) >= rr_ptr) begin
                    hi_pick  = SEL_W'(k);
                    hi_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_ok   = 1'b0;
        grant_oh = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_ok = 1'b1;
            end
        end
        if (!mode) begin
            for (int k = 0; k < N; k++) begin
                if (sel == SEL_W'(k) && in_valid[k]) begin
                    grant_oh[k] = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (hi_found && hi_pick == SEL_W'(k)) begin
                    grant_oh[k] = 1'b1;
                end else if (!hi_found && lo_found && lo_pick == SEL_W'(k)) begin
                    grant_oh[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        rr_next    = rr_ptr;
        for (int k = 0; k < N; k++) begin
            if (grant_oh[k]) begin
                grant_idx  = SEL_W'(k);
                grant_data = in_data[k*WIDTH +: WIDTH];
                rr_next    = (k == N - 1) ? '0 : SEL_W'(k + 1);
            end
        end
    end

    assign grant_any = |grant_oh;
    assign in_ready  = grant_oh & {N{load_en & ~Rst}};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            sel_err <= ~mode & ~sel_ok & load_en;
            if (load_en) begin
                if (grant_any) begin
                    out_data  <= grant_data;
                    out_sel   <= grant_idx;
                    out_valid <= 1'b1;
                    if (mode) begin
                        rr_ptr <= rr_next;
                    end
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_pipe_n_to_1.sv
// Directed bench for mux_pipe_n_to_1: a vector table for the N=4 instance plus
// hand-written sequences for backpressure, mid-run reset and out-of-range select (N=3).
module tb_mux_pipe_n_to_1;

    logic        Clk;
    logic        Rst;

    logic [19:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [4:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;

    logic [14:0] in_data_3;
    logic [2:0]  in_valid_3;
    logic [2:0]  in_ready_3;
    logic [1:0]  sel_3;
    logic        mode_3;
    logic [4:0]  out_data_3;
    logic [1:0]  out_sel_3;
    logic        out_valid_3;
    logic        out_ready_3;
    logic        sel_err_3;

    int errors = 0;
    int checks = 0;

    mux_pipe_n_to_1 #(.WIDTH(5), .N(4), .SEL_W(2)) dut (
        .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .mode(mode), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
    );

    mux_pipe_n_to_1 #(.WIDTH(5), .N(3), .SEL_W(2)) dut_3 (
        .Clk(Clk), .Rst(Rst), .in_data(in_data_3), .in_valid(in_valid_3), .in_ready(in_ready_3),
        .sel(sel_3), .mode(mode_3), .out_data(out_data_3), .out_sel(out_sel_3),
        .out_valid(out_valid_3), .out_ready(out_ready_3), .sel_err(sel_err_3)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        rst;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [19:0] data;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [4:0]  exp_od;
        logic [1:0]  exp_os;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [19:0] pack4(input logic [4:0] c3, input logic [4:0] c2,
                                          input logic [4:0] c1, input logic [4:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic ov, input logic [4:0] od,
                             input logic [1:0] os);
        check({name, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({name, ".out_data"}, 32'(out_data), 32'(od));
        check({name, ".out_sel"}, 32'(out_sel), 32'(os));
    endtask

    initial begin
        // reset, explicit select, round-robin fairness and wrap, mode switch
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 4'b1111, pack4(5'd4, 5'd3, 5'd2, 5'd1), 1'b1, 4'b0000, 1'b0, 5'h00, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 4'b1111, pack4(5'd4, 5'd3, 5'd2, 5'd1), 1'b1, 4'b0000, 1'b0, 5'h00, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 4'b0100, pack4(5'd0, 5'h15, 5'd0, 5'd0), 1'b1, 4'b0100, 1'b1, 5'h15, 2'd2};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 4'b0100, pack4(5'd0, 5'h15, 5'd0, 5'd0), 1'b1, 4'b0000, 1'b0, 5'h15, 2'd2};
        vecs[4]  = '{1'b0, 1'b1, 2'd0, 4'b1111, pack4(5'd11, 5'd10, 5'd9, 5'd8), 1'b1, 4'b0001, 1'b1, 5'd8,  2'd0};
        vecs[5]  = '{1'b0, 1'b1, 2'd0, 4'b1111, pack4(5'd11, 5'd10, 5'd9, 5'd8), 1'b1, 4'b0010, 1'b1, 5'd9,  2'd1};
        vecs[6]  = '{1'b0, 1'b1, 2'd0, 4'b1111, pack4(5'd11, 5'd10, 5'd9, 5'd8), 1'b1, 4'b0100, 1'b1, 5'd10, 2'd2};
        vecs[7]  = '{1'b0, 1'b1, 2'd0, 4'b1111, pack4(5'd11, 5'd10, 5'd9, 5'd8), 1'b1, 4'b1000, 1'b1, 5'd11, 2'd3};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 4'b1111, pack4(5'd11, 5'd10, 5'd9, 5'd8), 1'b1, 4'b0001, 1'b1, 5'd8,  2'd0};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 4'b1001, pack4(5'd11, 5'd10, 5'd9, 5'd8), 1'b1, 4'b1000, 1'b1, 5'd11, 2'd3};
        vecs[10] = '{1'b0, 1'b1, 2'd0, 4'b1001, pack4(5'd11, 5'd10, 5'd9, 5'd8), 1'b1, 4'b0001, 1'b1, 5'd8,  2'd0};
        vecs[11] = '{1'b0, 1'b0, 2'd1, 4'b0010, pack4(5'd0, 5'd0, 5'h0A, 5'd0), 1'b1, 4'b0010, 1'b1, 5'h0A, 2'd1};

        Rst = 1'b1;
        in_data = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b1;
        in_data_3 = '0; in_valid_3 = '0; sel_3 = '0; mode_3 = 1'b0; out_ready_3 = 1'b1;
        #2;

        for (int i = 0; i < 12; i++) begin
            Rst       = vecs[i].rst;
            mode      = vecs[i].mode;
            sel       = vecs[i].sel;
            in_valid  = vecs[i].valid;
            in_data   = vecs[i].data;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_os);
            check($sformatf("vec%0d.sel_err", i), 32'(sel_err), 32'd0);
        end

        // backpressure: entry 0A from ch1 must hold for 5 cycles, even across a mode flip
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        in_data   = pack4(5'd1, 5'd2, 5'd3, 5'd4);
        for (int i = 0; i < 5; i++) begin
            mode = (i >= 3);
            #1;
            check($sformatf("stall%0d.in_ready", i), 32'(in_ready), 32'd0);
            tick();
            check_out($sformatf("stall%0d", i), 1'b1, 5'h0A, 2'd1);
        end
        mode      = 1'b0;
        out_ready = 1'b1;
        sel       = 2'd3;
        in_valid  = 4'b1000;
        in_data   = pack4(5'h1F, 5'd0, 5'd0, 5'd0);
        #1;
        check("drain.in_ready", 32'(in_ready), 32'b1000);
        tick();
        check_out("drain", 1'b1, 5'h1F, 2'd3);

        // rr_ptr was 1 before the explicit-mode transfers and must still be 1
        mode     = 1'b1;
        in_valid = 4'b1111;
        in_data  = pack4(5'd11, 5'd10, 5'd9, 5'd8);
        #1;
        check("rr_hold.in_ready", 32'(in_ready), 32'b0010);
        tick();
        check_out("rr_hold", 1'b1, 5'd9, 2'd1);

        // mid-run reset: stalled full entry, rr_ptr=2, then reset for one cycle
        out_ready = 1'b0;
        Rst       = 1'b1;
        #1;
        check("rst_mid.in_ready", 32'(in_ready), 32'd0);
        tick();
        check_out("rst_mid", 1'b0, 5'd0, 2'd0);
        Rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_rr.in_ready", 32'(in_ready), 32'b0001);
        tick();
        check_out("rst_rr", 1'b1, 5'd8, 2'd0);

        // N=3 instance: out-of-range select pulses sel_err once and transfers nothing
        mode_3     = 1'b0;
        sel_3      = 2'd3;
        in_valid_3 = 3'b111;
        in_data_3  = {5'd3, 5'd2, 5'h07};
        #1;
        check("oor.in_ready", 32'(in_ready_3), 32'd0);
        tick();
        check("oor.sel_err", 32'(sel_err_3), 32'd1);
        check("oor.out_valid", 32'(out_valid_3), 32'd0);
        sel_3 = 2'd0;
        #1;
        check("oor_clr.in_ready", 32'(in_ready_3), 32'b001);
        tick();
        check("oor_clr.sel_err", 32'(sel_err_3), 32'd0);
        check("oor_clr.out_data", 32'(out_data_3), 32'h07);
        check("oor_clr.out_valid", 32'(out_valid_3), 32'd1);

        // out-of-range select while stalled raises no error
        out_ready_3 = 1'b0;
        sel_3       = 2'd3;
        tick();
        check("oor_stall.sel_err", 32'(sel_err_3), 32'd0);
        check("oor_stall.out_data", 32'(out_data_3), 32'h07);

        // round-robin wraps at N=3: 0,1,2,0
        out_ready_3 = 1'b1;
        mode_3      = 1'b1;
        in_data_3   = {5'd12, 5'd11, 5'd10};
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr3_%0d.out_sel", i), 32'(out_sel_3), 32'(i % 3));
            check($sformatf("rr3_%0d.out_data", i), 32'(out_data_3), 32'(10 + (i % 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
